v2_queue: RTL and testbench

Parametrised successor to the v1 controller-plus-datapath queue, with storage, pointers and control in a single block. Adds simultaneous push_back/pop_front in one cycle, synchronous clear, an occupancy count and a combinational front peek. Storage is a circular buffer with separate head and tail pointers and supports any depth ≥ 2, not only powers of two. It replaces v1 queue instances wherever a full-throughput FIFO with registered pop data is required.

---
 rtl/v2_queue.sv | 92 +++++++++
 tb/tb_v2_queue.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/v2_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// v2_queue : circular-buffer FIFO with same-cycle push/pop, clear, count, peek
// Revision : 1.0
// ----------------------------------------------------------------------------
module v2_queue #(
  parameter int p_depth    = 32,
  parameter int p_bitwidth = 32,
  parameter int p_ptrwidth = $clog2(p_depth),
  parameter int p_cntwidth = $clog2(p_depth + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_back_en,
  output logic                  push_back_rdy,
  input  logic [p_bitwidth-1:0] push_back_data,
  input  logic                  pop_front_en,
  output logic                  pop_front_rdy,
  output logic [p_bitwidth-1:0] pop_front_data,
  output logic [p_bitwidth-1:0] peek_data,
  input  logic                  clear,
  output logic [p_cntwidth-1:0] count
);

  localparam logic [p_cntwidth-1:0] c_depth   = p_cntwidth'(p_depth);
  localparam logic [p_cntwidth-1:0] c_cnt_one = p_cntwidth'(1);
  localparam logic [p_ptrwidth-1:0] c_ptr_max = p_ptrwidth'(p_depth - 1);
  localparam logic [p_ptrwidth-1:0] c_ptr_one = p_ptrwidth'(1);

  logic [p_bitwidth-1:0] mem_q [p_depth];
  logic [p_ptrwidth-1:0] head_q, head_d;
  logic [p_ptrwidth-1:0] tail_q, tail_d;
  logic [p_cntwidth-1:0] count_q, count_d;
  logic [p_bitwidth-1:0] pop_data_q, pop_data_d;

  logic w_push_fire;
  logic w_pop_fire;

  // Explicit wrap keeps pointers legal for non-power-of-two depths.
  function automatic logic [p_ptrwidth-1:0] next_ptr(input logic [p_ptrwidth-1:0] p);
    return (p == c_ptr_max) ? '0 : p + c_ptr_one;
  endfunction

  assign push_back_rdy  = (count_q != c_depth);
  assign pop_front_rdy  = (count_q != '0);
  assign w_push_fire    = push_back_en && push_back_rdy;
  assign w_pop_fire     = pop_front_en && pop_front_rdy;
  assign count          = count_q;
  assign pop_front_data = pop_data_q;
  assign peek_data      = (count_q != '0) ? mem_q[head_q] : '0;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    pop_data_d = pop_data_q;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (w_push_fire) tail_d = next_ptr(tail_q);
      if (w_pop_fire) begin
        head_d     = next_ptr(head_q);
        pop_data_d = mem_q[head_q];
      end
      if (w_push_fire && !w_pop_fire) count_d = count_q + c_cnt_one;
      else if (w_pop_fire && !w_push_fire) count_d = count_q - c_cnt_one;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      pop_data_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      pop_data_q <= pop_data_d;
    end
  end

  // Storage is intentionally unreset; a cleared push never lands.
  always_ff @(posedge clk) begin
    if (w_push_fire && !clear) mem_q[tail_q] <= push_back_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_v2_queue.sv
`default_nettype none
// Directed bench for v2_queue (depth 5) with a queue-based reference model.
module tb_v2_queue;

  localparam int DEPTH = 5;
  localparam int BW    = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          push_back_en = 1'b0;
  logic          push_back_rdy;
  logic [BW-1:0] push_back_data = '0;
  logic          pop_front_en = 1'b0;
  logic          pop_front_rdy;
  logic [BW-1:0] pop_front_data;
  logic [BW-1:0] peek_data;
  logic          clear = 1'b0;
  logic [CW-1:0] count;

  v2_queue #(.p_depth(DEPTH), .p_bitwidth(BW)) dut (
    .clk           (clk),
    .rst           (rst),
    .push_back_en  (push_back_en),
    .push_back_rdy (push_back_rdy),
    .push_back_data(push_back_data),
    .pop_front_en  (pop_front_en),
    .pop_front_rdy (pop_front_rdy),
    .pop_front_data(pop_front_data),
    .peek_data     (peek_data),
    .clear         (clear),
    .count         (count)
  );

  always #5 clk = ~clk;

  int            errors = 0;
  int            checks = 0;
  logic [BW-1:0] sb[$];
  logic [BW-1:0] exp_pop = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":count"}, 32'(count), 32'(sb.size()));
    chk({tag, ":push_rdy"}, 32'(push_back_rdy), 32'(sb.size() != DEPTH));
    chk({tag, ":pop_rdy"}, 32'(pop_front_rdy), 32'(sb.size() != 0));
    chk({tag, ":pop_data"}, 32'(pop_front_data), 32'(exp_pop));
    chk({tag, ":peek"}, 32'(peek_data), (sb.size() != 0) ? 32'(sb[0]) : 32'd0);
  endtask

  // One clock: drive at negedge, update model from pre-edge state, check after edge.
  task automatic step(input string tag, input logic pe, input logic [BW-1:0] pd,
                      input logic qe, input logic cl);
    logic push_ok, pop_ok;
    @(negedge clk);
    push_back_en   = pe;
    push_back_data = pd;
    pop_front_en   = qe;
    clear          = cl;
    push_ok = pe && (sb.size() < DEPTH);
    pop_ok  = qe && (sb.size() > 0);
    if (cl) sb.delete();
    else begin
      if (pop_ok) exp_pop = sb.pop_front();
      if (push_ok) sb.push_back(pd);
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    // Reset values while rst is held low, before any clock edge.
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // Basic push A, B, C then three pops.
    step("push_a", 1'b1, 8'h0A, 1'b0, 1'b0);
    step("push_b", 1'b1, 8'h0B, 1'b0, 1'b0);
    step("push_c", 1'b1, 8'h0C, 1'b0, 1'b0);
    step("pop_1", 1'b0, 8'h00, 1'b1, 1'b0);
    step("pop_2", 1'b0, 8'h00, 1'b1, 1'b0);
    step("pop_3", 1'b0, 8'h00, 1'b1, 1'b0);

    // Fill to depth, overflow push ignored, then wrap the tail.
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, BW'(8'h10 + i), 1'b0, 1'b0);
    step("overflow", 1'b1, 8'hEE, 1'b0, 1'b0);
    step("wrap_pop1", 1'b0, 8'h00, 1'b1, 1'b0);
    step("wrap_pop2", 1'b0, 8'h00, 1'b1, 1'b0);
    step("wrap_push1", 1'b1, 8'h20, 1'b0, 1'b0);
    step("wrap_push2", 1'b1, 8'h21, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step("wrap_drain", 1'b0, 8'h00, 1'b1, 1'b0);
    step("underflow", 1'b0, 8'h00, 1'b1, 1'b0);

    // Sustained simultaneous push/pop at count 2.
    step("tp_pre1", 1'b1, 8'h30, 1'b0, 1'b0);
    step("tp_pre2", 1'b1, 8'h31, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step("tp", 1'b1, BW'(8'h40 + i * 3), 1'b1, 1'b0);

    // Both requests at full: only the pop fires.
    for (int i = 0; i < 3; i++) step("top_up", 1'b1, BW'(8'h60 + i), 1'b0, 1'b0);
    step("both_full", 1'b1, 8'h77, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    // Both requests at empty: only the push fires, pop data holds.
    step("both_empty", 1'b1, 8'h88, 1'b1, 1'b0);

    // Clear with concurrent push and pop at count 3.
    step("pre_clr1", 1'b1, 8'h91, 1'b0, 1'b0);
    step("pre_clr2", 1'b1, 8'h92, 1'b0, 1'b0);
    step("clear", 1'b1, 8'h93, 1'b1, 1'b1);
    step("post_clr", 1'b1, 8'h94, 1'b0, 1'b0);
    step("post_clr_pop", 1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle at count 4.
    for (int i = 0; i < 4; i++) step("pre_rst", 1'b1, BW'(8'hA0 + i), 1'b0, 1'b0);
    #3;
    rst = 1'b0;
    sb.delete();
    exp_pop = '0;
    #1;
    check_all("async_rst");
    @(negedge clk);
    push_back_en = 1'b0;
    pop_front_en = 1'b0;
    clear        = 1'b0;
    rst          = 1'b1;
    step("after_rst_idle", 1'b0, 8'h00, 1'b1, 1'b0);
    step("after_rst_push", 1'b1, 8'hB5, 1'b0, 1'b0);
    step("after_rst_pop", 1'b0, 8'h00, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
